// File: rtl/ysyx_23060136_ifu_bht.sv
// ============================================================================
// Module   : ysyx_23060136_ifu_bht
// Brief    : Fetch-side branch history table of 2-bit saturating counters,
//            trained by EXU2 verdicts, with hit/miss performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ysyx_23060136_BITS_W
`define ysyx_23060136_BITS_W 32
`endif

module ysyx_23060136_ifu_bht #(
    parameter int ENTRIES = 16,
    parameter int BITS_W  = `ysyx_23060136_BITS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS_W-1:0] IFU_pc,
    output logic              IFU_pre_take,
    input  logic [BITS_W-1:0] BHT_pc,
    input  logic              BHT_pre_take,
    input  logic              BHT_pre_true,
    input  logic              BHT_pre_false,
    output logic [31:0]       BHT_hit_cnt,
    output logic [31:0]       BHT_miss_cnt
);

    localparam int         IDX_W      = $clog2(ENTRIES);
    localparam logic [1:0] C_CNT_RST  = 2'b01;
    localparam logic [1:0] C_CNT_MAX  = 2'b11;
    localparam logic [1:0] C_CNT_MIN  = 2'b00;
    localparam logic [31:0] C_PERF_MAX = 32'hFFFF_FFFF;

    logic [1:0]       table_q [ENTRIES];
    logic [31:0]      hit_cnt_q;
    logic [31:0]      hit_cnt_d;
    logic [31:0]      miss_cnt_q;
    logic [31:0]      miss_cnt_d;

    logic [IDX_W-1:0] w_ifu_idx;
    logic [IDX_W-1:0] w_bht_idx;
    logic             w_upd;
    logic             w_taken;
    logic [1:0]       w_cur_cnt;
    logic [1:0]       w_next_cnt;
    logic             w_unused_pc_bits;

    // No tags: the word-aligned low PC bits alone select the counter.
    assign w_ifu_idx = IFU_pc[IDX_W+1:2];
    assign w_bht_idx = BHT_pc[IDX_W+1:2];
    assign w_unused_pc_bits = ^{IFU_pc[BITS_W-1:IDX_W+2], IFU_pc[1:0],
                                BHT_pc[BITS_W-1:IDX_W+2], BHT_pc[1:0]};

    assign IFU_pre_take = table_q[w_ifu_idx][1];

    // Both verdict bits high is malformed and must not train anything.
    assign w_upd     = BHT_pre_true ^ BHT_pre_false;
    assign w_taken   = BHT_pre_take ^ BHT_pre_false;
    assign w_cur_cnt = table_q[w_bht_idx];

    always_comb begin
        w_next_cnt = w_cur_cnt;
        if (w_taken) begin
            if (w_cur_cnt != C_CNT_MAX) begin
                w_next_cnt = w_cur_cnt + 2'b01;
            end
        end else begin
            if (w_cur_cnt != C_CNT_MIN) begin
                w_next_cnt = w_cur_cnt - 2'b01;
            end
        end
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (BHT_pre_true && !BHT_pre_false && (hit_cnt_q != C_PERF_MAX)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (BHT_pre_false && !BHT_pre_true && (miss_cnt_q != C_PERF_MAX)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= C_CNT_RST;
            end
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (w_upd) begin
                table_q[w_bht_idx] <= w_next_cnt;
            end
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign BHT_hit_cnt  = hit_cnt_q;
    assign BHT_miss_cnt = miss_cnt_q;

endmodule

`default_nettype wire
